// File: rtl/fork2_reg.sv
// Registered eager fork: one valid/ready input stream is copied into two
// independently handshaked output branches. The input is accepted only once
// both branches have taken (or are taking this cycle) their copy of the token.
module fork2_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out_a,
  output logic                  valid_out_a,
  input  logic                  ready_out_a,
  output logic [DATA_WIDTH-1:0] data_out_b,
  output logic                  valid_out_b,
  input  logic                  ready_out_b
);

  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic                  pend_a_q, pend_a_d;
  logic                  pend_b_q, pend_b_d;
  logic                  done_a, done_b;
  logic                  accept;

  // Handshake decode and next-state: a fresh token overrides the per-branch clear.
  always_comb begin
    done_a     = !pend_a_q || ready_out_a;
    done_b     = !pend_b_q || ready_out_b;
    ready_in   = done_a && done_b;
    accept     = valid_in && ready_in;
    buf_data_d = buf_data_q;
    pend_a_d   = pend_a_q && !ready_out_a;
    pend_b_d   = pend_b_q && !ready_out_b;
    if (accept) begin
      buf_data_d = data_in;
      pend_a_d   = 1'b1;
      pend_b_d   = 1'b1;
    end
  end

  // State register; reset drops any in-flight token.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data_q <= '0;
      pend_a_q   <= 1'b0;
      pend_b_q   <= 1'b0;
    end else begin
      buf_data_q <= buf_data_d;
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
    end
  end

  // Outputs come straight from registers; no comb path from inputs to valid/data.
  always_comb begin
    data_out_a  = buf_data_q;
    data_out_b  = buf_data_q;
    valid_out_a = pend_a_q;
    valid_out_b = pend_b_q;
  end

endmodule

// File: tb/tb_fork2_reg.sv
// Self-checking bench for fork2_reg: directed scenarios followed by a
// random stress run against a per-branch queue scoreboard.
module tb_fork2_reg;

  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_in;
  logic [DW-1:0] data_out_a;
  logic          valid_out_a;
  logic          ready_out_a;
  logic [DW-1:0] data_out_b;
  logic          valid_out_b;
  logic          ready_out_b;

  int n_cmp = 0;
  int n_err = 0;

  fork2_reg #(
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .ready_in    (ready_in),
    .data_out_a  (data_out_a),
    .valid_out_a (valid_out_a),
    .ready_out_a (ready_out_a),
    .data_out_b  (data_out_b),
    .valid_out_b (valid_out_b),
    .ready_out_b (ready_out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic          acc_last;
  logic          exp_va, exp_vb, exp_rdy;

  initial begin
    valid_in    = 1'b0;
    data_in     = '0;
    ready_out_a = 1'b0;
    ready_out_b = 1'b0;
    rst_n       = 1'b1;
    #1 rst_n = 1'b0;

    // Reset defaults while other inputs toggle
    for (int i = 0; i < 3; i++) begin
      tick();
      valid_in    = 1'b1;
      data_in     = $urandom;
      ready_out_a = i[0];
      ready_out_b = i[1];
      #1;
      check("rst_ready_in", ready_in, 1);
      check("rst_valid_a", valid_out_a, 0);
      check("rst_valid_b", valid_out_b, 0);
      check("rst_data_a", data_out_a, 0);
      check("rst_data_b", data_out_b, 0);
    end
    tick();
    rst_n       = 1'b1;
    valid_in    = 1'b0;
    ready_out_a = 1'b1;
    ready_out_b = 1'b1;

    // Full throughput: 1, 2, 3 on consecutive cycles
    data_in  = 1;
    valid_in = 1'b1;
    #1 check("thr_ready_first", ready_in, 1);
    for (int v = 1; v <= 3; v++) begin
      tick();
      data_in = v + 1;
      if (v == 3) valid_in = 1'b0;
      #1;
      check("thr_valid_a", valid_out_a, 1);
      check("thr_data_a", data_out_a, v);
      check("thr_valid_b", valid_out_b, 1);
      check("thr_data_b", data_out_b, v);
      check("thr_ready_in", ready_in, 1);
    end
    tick();
    check("thr_drain_a", valid_out_a, 0);
    check("thr_drain_b", valid_out_b, 0);

    // Skewed acceptance: A ready, B stalled for 3 cycles
    ready_out_b = 1'b0;
    valid_in    = 1'b1;
    data_in     = 32'hA5;
    tick();
    valid_in = 1'b0;
    #1;
    check("skw_c1_valid_a", valid_out_a, 1);
    check("skw_c1_data_a", data_out_a, 32'hA5);
    check("skw_c1_valid_b", valid_out_b, 1);
    check("skw_c1_ready_in", ready_in, 0);
    tick();
    check("skw_c2_valid_a", valid_out_a, 0);
    check("skw_c2_valid_b", valid_out_b, 1);
    check("skw_c2_data_b", data_out_b, 32'hA5);
    check("skw_c2_ready_in", ready_in, 0);
    tick();
    check("skw_c3_valid_a", valid_out_a, 0);
    check("skw_c3_valid_b", valid_out_b, 1);
    check("skw_c3_data_b", data_out_b, 32'hA5);
    check("skw_c3_ready_in", ready_in, 0);
    ready_out_b = 1'b1;
    #1 check("skw_rise_ready_in", ready_in, 1);
    tick();
    check("skw_done_valid_b", valid_out_b, 0);

    // Back-to-back refill from ONLY_B
    ready_out_b = 1'b0;
    valid_in    = 1'b1;
    data_in     = 32'h10;
    tick();
    valid_in = 1'b0;
    tick();
    check("ref_only_b_va", valid_out_a, 0);
    check("ref_only_b_vb", valid_out_b, 1);
    check("ref_only_b_db", data_out_b, 32'h10);
    valid_in    = 1'b1;
    data_in     = 32'h11;
    ready_out_b = 1'b1;
    #1 check("ref_ready_in", ready_in, 1);
    tick();
    valid_in = 1'b0;
    #1;
    check("ref_va", valid_out_a, 1);
    check("ref_vb", valid_out_b, 1);
    check("ref_da", data_out_a, 32'h11);
    check("ref_db", data_out_b, 32'h11);
    tick();
    check("ref_drain_b", valid_out_b, 0);

    // Mid-operation reset in BOTH
    ready_out_a = 1'b0;
    ready_out_b = 1'b0;
    valid_in    = 1'b1;
    data_in     = 32'h55;
    tick();
    valid_in = 1'b0;
    #1;
    check("mrst_pre_vb", valid_out_b, 1);
    check("mrst_pre_da", data_out_a, 32'h55);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_va", valid_out_a, 0);
    check("mrst_vb", valid_out_b, 0);
    check("mrst_da", data_out_a, 0);
    check("mrst_ready_in", ready_in, 1);
    tick();
    rst_n       = 1'b1;
    ready_out_a = 1'b1;
    ready_out_b = 1'b1;
    valid_in    = 1'b1;
    data_in     = 32'h66;
    tick();
    valid_in = 1'b0;
    #1;
    check("mrst_new_da", data_out_a, 32'h66);
    check("mrst_new_db", data_out_b, 32'h66);
    check("mrst_new_va", valid_out_a, 1);
    check("mrst_new_vb", valid_out_b, 1);
    tick();
    check("mrst_end_va", valid_out_a, 0);
    check("mrst_end_vb", valid_out_b, 0);

    // Random stress against per-branch queues (block is empty here)
    acc_last = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      tick();
      if (!valid_in || acc_last) begin
        valid_in = 1'($urandom_range(0, 1));
        data_in  = $urandom;
      end
      ready_out_a = ($urandom_range(0, 3) != 0);
      ready_out_b = ($urandom_range(0, 2) != 0);
      #1;
      exp_va  = (qa.size() != 0);
      exp_vb  = (qb.size() != 0);
      exp_rdy = (!exp_va || ready_out_a) && (!exp_vb || ready_out_b);
      check("rnd_valid_a", valid_out_a, exp_va);
      check("rnd_valid_b", valid_out_b, exp_vb);
      check("rnd_ready_in", ready_in, exp_rdy);
      if (exp_va) check("rnd_data_a", data_out_a, qa[0]);
      if (exp_vb) check("rnd_data_b", data_out_b, qb[0]);
      if (exp_va && ready_out_a) void'(qa.pop_front());
      if (exp_vb && ready_out_b) void'(qb.pop_front());
      acc_last = valid_in && exp_rdy;
      if (acc_last) begin
        qa.push_back(data_in);
        qb.push_back(data_in);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fork2_reg.md
# fork2_reg

Registered eager fork that copies one valid/ready stream into two independent output branches, each with its own handshake. It sits directly upstream of `join2` in split/merge (diamond) datapaths: one token enters, both branches receive a copy, and the branches are later resynchronised by `join2`. Each branch may accept its copy in a different cycle. The input is not released until both copies have been taken.

## Interface
- `DATA_WIDTH`, default 32: payload width in bits.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `data_in` input DATA_WIDTH: input payload.
- `valid_in` input 1: input token valid.
- `ready_in` output 1: block can accept a token this cycle.
- `data_out_a` output DATA_WIDTH: branch A payload.
- `valid_out_a` output 1: branch A copy pending.
- `ready_out_a` input 1: branch A consumer ready.
- `data_out_b` output DATA_WIDTH: branch B payload.
- `valid_out_b` output 1: branch B copy pending.
- `ready_out_b` input 1: branch B consumer ready.

## Operation
- State:
  - `buf_data` [DATA_WIDTH-1:0]: one-entry holding register.
  - `pend_a`, `pend_b`: flags meaning "this branch has not yet taken the current token".
- Outputs:
  - `data_out_a = data_out_b = buf_data`.
  - `valid_out_a = pend_a`; `valid_out_b = pend_b`.
- Per-branch "done this cycle":
  - `done_a = !pend_a | ready_out_a`.
  - `done_b = !pend_b | ready_out_b`.
- `ready_in = done_a & done_b`. This is combinational from `ready_out_*` by design, so the block can sustain 1 token/cycle.
- Input handshake (`valid_in & ready_in`): `buf_data <= data_in`, `pend_a <= 1`, `pend_b <= 1`. This takes priority over the clear rule below.
- Otherwise:
  - `pend_a <= pend_a & !ready_out_a`.
  - `pend_b <= pend_b & !ready_out_b`.
  - `buf_data` holds.
- Effective states (`pend_a`, `pend_b`):
  - EMPTY (0,0): on input handshake → BOTH.
  - BOTH (1,1): A and B accept together → BOTH if a new input is accepted, else EMPTY. A only → ONLY_B. B only → ONLY_A.
  - ONLY_A (1,0): A accepts → BOTH if a new input is accepted, else EMPTY.
  - ONLY_B (0,1): B accepts → BOTH if a new input is accepted, else EMPTY.
- A branch never sees the same token twice. A branch never misses a token.
- `buf_data` changes only on an input handshake.

## Timing
- Reset (async assert, any time, including mid-transfer):
  - `pend_a = pend_b = 0`, `buf_data = 0`.
  - Therefore `valid_out_a = valid_out_b = 0`, `data_out_a = data_out_b = 0`, `ready_in = 1`.
  - Any in-flight token is dropped.
- Reset release: first handshake possible on the first rising edge with `rst_n = 1`.
- Latency: 1 cycle. A token accepted at edge N shows `valid_out_a/b = 1` from edge N until that branch's handshake.
- Throughput:
  - 1 token/cycle while both branches are ready.
  - With a stalled branch, `ready_in = 0` until the stalled branch takes its copy.
- Simultaneous events: in the same cycle as the last pending branch handshake, a new input is accepted. Flags go directly to (1,1) and `buf_data` takes the new value; there is no bubble.
- Upstream rules: `data_in` and `valid_in` must be held stable until accepted. The block does not depend on `valid_in` for `ready_in`.
- Downstream guarantee: while `valid_out_x = 1` and `ready_out_x = 0`, `data_out_x` and `valid_out_x` are held stable.
- No `valid_out` → `ready` combinational dependency on inputs. `valid_out_*` and `data_out_*` are register outputs.

## Test plan
- Reset defaults: hold `rst_n = 0`, toggle other inputs → `ready_in = 1`, both `valid_out = 0`, both `data_out = 0`.
- Full throughput: both ready held at 1, stream 0x1, 0x2, 0x3 on consecutive cycles → each branch outputs 0x1, 0x2, 0x3 one cycle later; `ready_in` stays 1.
- Skewed acceptance: push 0xA5, `ready_out_a = 1`, `ready_out_b = 0` for 3 cycles, then 1 →
  - A takes 0xA5 once, then `valid_out_a = 0`.
  - `valid_out_b` holds with 0xA5 for 3 cycles.
  - `ready_in = 0` for 3 cycles.
  - `ready_in = 1` in the cycle `ready_out_b` rises.
- Back-to-back refill: state ONLY_B holding 0x10, `valid_in = 1` with 0x11, `ready_out_b` rises → same edge: B takes 0x10, 0x11 is loaded, both valid next cycle.
- Mid-operation reset: assert `rst_n = 0` in BOTH holding 0x55 → `valid_out_a/b` drop to 0 asynchronously; after release, a new token 0x66 is delivered to both branches and 0x55 is never seen again.
- Random stress: random `valid_in` and `ready_out_a/b` over 10k cycles → the scoreboard sees each branch receive the input sequence exactly once and in order, and the stability rules hold.
